// File: rtl/hex_display_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hex_display_ctrl_if
// Control/display bundle between game logic (master) and the
// 7-segment driver (slave).
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
interface hex_display_ctrl_if #(
  parameter int NUM_DIGITS = 6
);

  // Control side: written by the game/control logic.
  logic                      load;
  logic [4*NUM_DIGITS-1:0]   value;
  logic                      clr;
  logic                      lz_en;
  logic [NUM_DIGITS-1:0]     blink_mask;
  logic                      lamp_test;

  // Display side: produced by the driver and routed to the HEX pins.
  logic [7*NUM_DIGITS-1:0]   hex_out;
  logic                      blink_phase;

  modport master (
    output load,
    output value,
    output clr,
    output lz_en,
    output blink_mask,
    output lamp_test,
    input  hex_out,
    input  blink_phase
  );

  modport slave (
    input  load,
    input  value,
    input  clr,
    input  lz_en,
    input  blink_mask,
    input  lamp_test,
    output hex_out,
    output blink_phase
  );

endinterface
`default_nettype wire

// File: rtl/hex_display_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hex_display_ctrl
// Registered driver for NUM_DIGITS active-low 7-segment digits with a
// loadable display register, leading-zero suppression, per-digit blink
// at a divided rate, synchronous clear and lamp test.
// Segment order per digit is gfedcba, 0 = segment lit.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module hex_display_ctrl #(
  parameter int NUM_DIGITS = 6,
  parameter int BLINK_DIV  = 25000000
) (
  input  wire logic              clk,
  input  wire logic              rst,
  hex_display_ctrl_if.slave      hex_if
);

  // A BLINK_DIV of 1 would collapse the counter to zero bits; keep at least one.
  localparam int              CNT_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);
  localparam int              VAL_W   = 4 * NUM_DIGITS;
  localparam int              HEX_W   = 7 * NUM_DIGITS;

  // Display register: one nibble per digit, 0xF shows as blank.
  logic [VAL_W-1:0]      disp_q;
  logic [VAL_W-1:0]      disp_d;

  // Free-running blink divider and the phase it produces.
  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      cnt_d;
  logic                  phase_q;
  logic                  phase_d;

  // Registered segment outputs.
  logic [HEX_W-1:0]      hex_q;
  logic [HEX_W-1:0]      hex_d;

  // Per-digit leading-zero blank flags.
  logic [NUM_DIGITS-1:0] lz_sup;

  // Team glyph map; every 4-bit code has a defined pattern.
  function automatic logic [6:0] glyph(input logic [3:0] code);
    logic [6:0] seg;
    case (code)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1110111;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      default: seg = 7'b1111111;
    endcase
    return seg;
  endfunction

  // Display register next value: clear beats load, otherwise hold.
  always_comb begin
    disp_d = disp_q;
    if (hex_if.clr) begin
      disp_d = '1;
    end else if (hex_if.load) begin
      disp_d = hex_if.value;
    end
  end

  // Blink divider: wraps at BLINK_DIV-1 and flips the phase on the wrap edge.
  always_comb begin
    cnt_d   = cnt_q + CNT_W'(1);
    phase_d = phase_q;
    if (cnt_q == CNT_MAX) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end
  end

  // Leading-zero scan from the top digit down over the registered value;
  // any nonzero nibble (including 0xF) ends the run, digit 0 is always shown.
  always_comb begin
    logic run;
    run    = hex_if.lz_en;
    lz_sup = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      run       = run && (disp_q[4*i +: 4] == 4'h0);
      lz_sup[i] = run;
    end
  end

  // Per-digit segment selection in priority order:
  // lamp test, blink blank, leading-zero blank, glyph.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    logic [3:0] nib;
    logic [6:0] seg_d;

    assign nib = disp_q[4*gi +: 4];

    // Select the segment pattern for this digit.
    always_comb begin
      seg_d = glyph(nib);
      if (hex_if.lamp_test) begin
        seg_d = 7'b0000000;
      end else if (phase_q && hex_if.blink_mask[gi]) begin
        seg_d = 7'b1111111;
      end else if (lz_sup[gi]) begin
        seg_d = 7'b1111111;
      end
    end

    assign hex_d[7*gi +: 7] = seg_d;
  end

  // Display register; reset leaves every digit blank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_q <= '1;
    end else begin
      disp_q <= disp_d;
    end
  end

  // Blink divider and phase; unaffected by load, clr or mask.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  // Output register, giving one cycle from register/phase/controls to pins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hex_q <= '1;
    end else begin
      hex_q <= hex_d;
    end
  end

  assign hex_if.hex_out     = hex_q;
  assign hex_if.blink_phase = phase_q;

endmodule
`default_nettype wire

// File: tb/tb_hex_display_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_hex_display_ctrl
// Scoreboard bench for hex_display_ctrl (NUM_DIGITS=6, BLINK_DIV=4).
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_hex_display_ctrl;

  localparam int ND = 6;
  localparam int BD = 4;
  localparam int VW = 4 * ND;
  localparam int HW = 7 * ND;

  localparam logic [HW-1:0] ALL_ONES = '1;
  localparam logic [6:0] S_BLANK = 7'b1111111;
  localparam logic [6:0] S_ON    = 7'b0000000;
  localparam logic [6:0] S_0     = 7'b1000000;

  logic clk = 1'b0;
  logic rst;

  hex_display_ctrl_if #(.NUM_DIGITS(ND)) hif ();

  hex_display_ctrl #(
    .NUM_DIGITS (ND),
    .BLINK_DIV  (BD)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .hex_if (hif.slave)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [HW-1:0] hex;
    logic          ph;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [VW-1:0] m_disp;
  int            m_cnt;
  logic          m_ph;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] ref_glyph(input logic [3:0] c);
    logic [6:0] t [16];
    t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
          7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
          7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
          7'b1110111, 7'b0100001, 7'b0000110, 7'b1111111};
    return t[c];
  endfunction

  function automatic logic [HW-1:0] model_hex(input logic [VW-1:0] disp, input logic ph,
                                               input logic lz, input logic [ND-1:0] mask,
                                               input logic lamp);
    logic [HW-1:0] h;
    logic          zero_run;
    logic [3:0]    nib;
    zero_run = 1'b1;
    h = '0;
    for (int i = ND - 1; i >= 0; i--) begin
      nib      = disp[4*i +: 4];
      zero_run = zero_run && (nib == 4'h0);
      if (lamp)                     h[7*i +: 7] = S_ON;
      else if (ph && mask[i])       h[7*i +: 7] = S_BLANK;
      else if (lz && zero_run && i != 0) h[7*i +: 7] = S_BLANK;
      else                          h[7*i +: 7] = ref_glyph(nib);
    end
    return h;
  endfunction

  task automatic model_reset();
    m_disp = '1;
    m_cnt  = 0;
    m_ph   = 1'b0;
    sb.delete();
  endtask

  // One clock: push expectation for this edge, advance model, then compare.
  task automatic step();
    exp_t e;
    exp_t got;
    e.hex = model_hex(m_disp, m_ph, hif.lz_en, hif.blink_mask, hif.lamp_test);
    if (hif.clr)       m_disp = '1;
    else if (hif.load) m_disp = hif.value;
    if (m_cnt == BD - 1) begin
      m_cnt = 0;
      m_ph  = ~m_ph;
    end else begin
      m_cnt++;
    end
    e.ph = m_ph;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    check("sb_hex", 64'(hif.hex_out), 64'(got.hex));
    check("sb_phase", 64'(hif.blink_phase), 64'(got.ph));
    @(negedge clk);
  endtask

  task automatic load_val(input logic [VW-1:0] v);
    hif.load  = 1'b1;
    hif.value = v;
    step();
    hif.load  = 1'b0;
    step();
  endtask

  initial begin
    int seen_blank;
    int seen_lit;
    rst            = 1'b1;
    hif.load       = 1'b0;
    hif.value      = '0;
    hif.clr        = 1'b0;
    hif.lz_en      = 1'b0;
    hif.blink_mask = '0;
    hif.lamp_test  = 1'b0;
    model_reset();

    // Reset state
    @(posedge clk);
    #1;
    check("rst_hex", 64'(hif.hex_out), 64'(ALL_ONES));
    check("rst_phase", 64'(hif.blink_phase), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    step();
    step();
    check("idle_hex", 64'(hif.hex_out), 64'(ALL_ONES));

    // Glyphs without and with leading-zero suppression
    load_val(24'h0012AF);
    check("glyph_0012AF", 64'(hif.hex_out),
          64'({S_0, S_0, 7'b1111001, 7'b0100100, 7'b0001000, S_BLANK}));
    hif.lz_en = 1'b1;
    step();
    check("lz_0012AF", 64'(hif.hex_out),
          64'({S_BLANK, S_BLANK, 7'b1111001, 7'b0100100, 7'b0001000, S_BLANK}));

    // All-zero value keeps one zero; an F ends the zero run
    load_val(24'h000000);
    check("lz_all_zero", 64'(hif.hex_out),
          64'({S_BLANK, S_BLANK, S_BLANK, S_BLANK, S_BLANK, S_0}));
    load_val(24'h0F0000);
    check("lz_f_stops", 64'(hif.hex_out),
          64'({S_BLANK, S_BLANK, S_0, S_0, S_0, S_0}));

    // Blink on the two low digits
    hif.lz_en      = 1'b0;
    hif.blink_mask = 6'b000011;
    load_val(24'h888888);
    seen_blank = 0;
    seen_lit   = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (hif.hex_out == {S_ON, S_ON, S_ON, S_ON, S_BLANK, S_BLANK}) seen_blank++;
      if (hif.hex_out == {S_ON, S_ON, S_ON, S_ON, S_ON, S_ON}) seen_lit++;
    end
    check("blink_dark_seen", 64'(seen_blank > 0), 64'd1);
    check("blink_lit_seen", 64'(seen_lit > 0), 64'd1);

    // clr beats load; lamp test overrides blink and suppression
    hif.clr   = 1'b1;
    hif.load  = 1'b1;
    hif.value = 24'h123456;
    step();
    hif.clr  = 1'b0;
    hif.load = 1'b0;
    step();
    check("clr_prio", 64'(hif.hex_out), 64'(ALL_ONES));
    hif.lz_en      = 1'b1;
    hif.blink_mask = 6'b111111;
    hif.lamp_test  = 1'b1;
    step();
    check("lamp_test", 64'(hif.hex_out), 64'd0);
    step();
    hif.lamp_test = 1'b0;
    step();

    // Random mix of controls
    for (int k = 0; k < 60; k++) begin
      logic [VW-1:0] v;
      for (int d = 0; d < ND; d++)
        v[4*d +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      hif.value      = v;
      hif.load       = ($urandom_range(0, 2) == 0);
      hif.clr        = ($urandom_range(0, 9) == 0);
      hif.lz_en      = ($urandom_range(0, 1) == 1);
      hif.blink_mask = ND'($urandom_range(0, 63));
      hif.lamp_test  = ($urandom_range(0, 11) == 0);
      step();
    end
    hif.load       = 1'b0;
    hif.clr        = 1'b0;
    hif.lamp_test  = 1'b0;
    hif.lz_en      = 1'b0;
    hif.blink_mask = 6'b000011;

    // Asynchronous reset mid-blink
    load_val(24'h876543);
    step();
    step();
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_hex", 64'(hif.hex_out), 64'(ALL_ONES));
    check("async_rst_phase", 64'(hif.blink_phase), 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    check("rst_hold_hex", 64'(hif.hex_out), 64'(ALL_ONES));
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= BD; k++) begin
      step();
      check("first_toggle", 64'(hif.blink_phase), 64'(k == BD));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hex_display_ctrl.md
Name: hex_display_ctrl

Overview:
- Registered, parametrised driver for a bank of NUM_DIGITS active-low 7-segment digits.
- Holds a loadable display value and applies the team's 4-bit glyph map per digit.
- Adds behaviour the plain decoder lacks: leading-zero suppression, per-digit blink at a divided rate, synchronous clear and lamp test.
- Sits between game/control logic and the board HEX pins; all outputs are registered.

Parameters:
- NUM_DIGITS, 6, number of digits driven (legal range 1..8).
- BLINK_DIV, 25000000, clock cycles per blink half-period (legal minimum 2).

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- load  input  1  capture value into display register this edge
- value  input  4*NUM_DIGITS  digit codes; nibble i drives digit i, nibble 0 = least significant
- clr  input  1  synchronous clear of display register to all-blank
- lz_en  input  1  enable leading-zero suppression
- blink_mask  input  NUM_DIGITS  bit i = 1 makes digit i blink
- lamp_test  input  1  force all segments on
- hex_out  output  7*NUM_DIGITS  segments of digit i at [7i+6:7i], bit order gfedcba, 0 = segment lit
- blink_phase  output  1  current blink phase, 1 = blinked digits dark

Behaviour:
- Reset (async, rst=1):
  - Display register = all 0xF.
  - Blink counter = 0; blink_phase = 0.
  - hex_out = all ones.
  - Outputs hold these values while rst is high; normal operation resumes on the first edge after release.
- Display register update at each edge:
  - clr=1: all nibbles become 0xF.
  - Else load=1: register becomes value.
  - Else: register holds.
  - clr has priority when clr and load are both 1.
- Glyph map, 0 = segment on, gfedcba:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000
  - 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000
  - 8 = 0000000, 9 = 0010000, A = 0001000, b = 0000011
  - C = 1110111 (underscore), d = 0100001, E = 0000110, F = 1111111 (blank)
- Leading-zero suppression (lz_en=1):
  - Scan from digit NUM_DIGITS-1 downward; each register nibble equal to 0x0 is blanked until the first nonzero nibble.
  - 0xF counts as nonzero and ends the run.
  - Digit 0 is never suppressed, so an all-zero value shows a single "0".
  - Suppression applies to the register contents, not to the raw value input.
- Blink:
  - Counter counts 0..BLINK_DIV-1 every cycle and wraps to 0.
  - blink_phase toggles on the edge where the counter wraps, giving a period of 2*BLINK_DIV cycles. First toggle occurs at edge BLINK_DIV after reset release.
  - While blink_phase=1, digits with blink_mask bit set are blank.
  - Counter is free-running: unaffected by load, clr or blink_mask changes.
- Output priority per digit, highest first:
  1. lamp_test: 0000000
  2. blink blank
  3. leading-zero blank
  4. glyph of register nibble
- Latency:
  - hex_out is registered from register contents, blink_phase, lz_en, blink_mask and lamp_test.
  - A load or clr at edge N appears on hex_out after edge N+1.
  - lz_en, blink_mask and lamp_test changes appear after the next edge, a 1-cycle latency.
  - blink_phase toggling at edge N affects hex_out after edge N+1.
- Width rules:
  - Blink counter width is clog2(BLINK_DIV).
  - No arithmetic is performed on the value input.
  - Unused glyph cases are impossible (full 4-bit map).

Test Plan:
- Reset, then release with no load -> hex_out = all ones for NUM_DIGITS=6 (42'h3FF_FFFF_FFFF); blink_phase = 0.
- load=1, value=24'h0012AF, lz_en=0 -> two edges later, digit5..0 = 1000000, 1000000, 1111001, 0100100, 0001000, 1111111. Repeat with lz_en=1 -> digits 5 and 4 become 1111111, others unchanged.
- lz_en=1, load value=24'h000000 -> digits 5..1 = 1111111 and digit 0 = 1000000. Then load 24'h0F0000 -> digit 5 blank, digit 4 blank (0xF), digits 3..0 show 1000000 (zero run ended by F).
- BLINK_DIV=4, load 24'h888888, blink_mask=6'b000011:
  - blink_phase toggles every 4 cycles.
  - While blink_phase=1 (plus one cycle of latency), digits 1..0 = 1111111 and digits 5..2 = 0000000.
- load and clr asserted on the same edge with value=24'h123456 -> register is all F and hex_out is all ones. lamp_test=1 afterwards -> hex_out is all zeros one cycle later, overriding blink and suppression.
- Assert rst mid-blink with value loaded -> hex_out goes all ones and blink_phase goes 0 immediately, without waiting for clk. After release, the first blink toggle occurs at edge BLINK_DIV.
